// File: rtl/lcd_msg_scheduler.sv
// lcd_msg_scheduler: picks which of the four LCD1602 messages is shown.
// Requests from the access-control logic are latched into a pending set and
// arbitrated ALARM > OPEN > PASS > USER. The block enforces the LCD power-up
// wait, a minimum on-screen time for non-alarm messages and an auto-return
// from OPEN to USER. It also stretches message_change so the LCD's slow
// refresh clock cannot miss it.
module lcd_msg_scheduler #(
  parameter int unsigned POWERUP_CYCLES  = 2500000,
  parameter int unsigned CHANGE_CYCLES   = 3200000,
  parameter int unsigned MIN_HOLD_CYCLES = 50000000,
  parameter int unsigned OPEN_CYCLES     = 150000000,
  parameter int unsigned DIGITS_W        = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_user,
  input  logic                req_pass,
  input  logic                req_open,
  input  logic                req_alarm,
  input  logic                alarm_clear,
  input  logic [DIGITS_W-1:0] digits_in,
  input  logic                digits_valid,
  output logic                ready_o,
  output logic [1:0]          sel_msg,
  output logic                message_change,
  output logic [DIGITS_W-1:0] data_out,
  output logic                busy
);

  localparam logic [1:0] MSG_USER  = 2'b00;
  localparam logic [1:0] MSG_PASS  = 2'b01;
  localparam logic [1:0] MSG_OPEN  = 2'b10;
  localparam logic [1:0] MSG_ALARM = 2'b11;

  localparam int unsigned BOOT_W = $clog2(POWERUP_CYCLES) + 1;
  localparam int unsigned CHG_W  = $clog2(CHANGE_CYCLES) + 1;
  localparam int unsigned HOLD_W = $clog2(MIN_HOLD_CYCLES) + 1;
  localparam int unsigned OPEN_W = $clog2(OPEN_CYCLES) + 1;

  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(POWERUP_CYCLES - 1);
  localparam logic [CHG_W-1:0]  CHG_LAST  = CHG_W'(CHANGE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MIN_HOLD_CYCLES);
  localparam logic [OPEN_W-1:0] OPEN_MAX  = OPEN_W'(OPEN_CYCLES);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_SHOW   = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  // Registered state
  state_t              state_q,   state_d;
  logic [BOOT_W-1:0]   boot_cnt_q, boot_cnt_d;
  logic [CHG_W-1:0]    chg_cnt_q,  chg_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [OPEN_W-1:0]   open_cnt_q, open_cnt_d;
  logic [3:0]          pend_q,     pend_d;
  logic                alarm_latch_q, alarm_latch_d;
  logic                ready_q,   ready_d;
  logic [1:0]          sel_q,     sel_d;
  logic                mc_q,      mc_d;
  logic [DIGITS_W-1:0] data_q,    data_d;
  logic                busy_q,    busy_d;

  // Arbitration helpers
  logic [3:0] req_vec;
  logic [3:0] req_eff;
  logic [3:0] pend_base;
  logic [3:0] sel_oh;
  logic [3:0] cand_vec;
  logic [1:0] cand;
  logic       cand_valid;
  logic       commit;
  logic       open_hit;
  logic       alarm_release;

  // Candidate selection: highest-priority pending-or-requested code that is not on screen
  always_comb begin
    // NOTE: every signal driven here gets a value on every path (defaults first),
    // otherwise synthesis infers a latch to hold the old value.
    req_vec   = {req_alarm, req_open, req_pass, req_user};
    sel_oh    = 4'b0001 << sel_q;
    // While the alarm is latched only ALARM survives, both as a request and as pending.
    req_eff   = alarm_latch_q ? {req_vec[3], 3'b000} : req_vec;
    pend_base = alarm_latch_q ? {pend_q[3], 3'b000}  : pend_q;
    cand_vec  = (pend_base | req_eff) & ~sel_oh;
    cand_valid = |cand_vec;
    cand = MSG_USER;
    if (cand_vec[3])      cand = MSG_ALARM;
    else if (cand_vec[2]) cand = MSG_OPEN;
    else if (cand_vec[1]) cand = MSG_PASS;
    commit = (state_q == ST_SHOW) && cand_valid &&
             ((cand == MSG_ALARM) || (hold_cnt_q == HOLD_MAX));
    open_hit = (state_q == ST_SHOW) && !commit && (sel_q == MSG_OPEN) &&
               (open_cnt_q == OPEN_MAX);
    // A simultaneous req_alarm keeps the alarm latched.
    alarm_release = alarm_latch_q && alarm_clear && !req_alarm;
  end

  // Next-state: FSM, counters, pending set, alarm latch and output registers
  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    chg_cnt_d     = chg_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    open_cnt_d    = open_cnt_q;
    alarm_latch_d = alarm_latch_q;
    ready_d       = ready_q;
    sel_d         = sel_q;
    mc_d          = mc_q;
    busy_d        = busy_q;
    data_d        = data_q;

    // Requests for the code already on screen are dropped; a committed code is
    // consumed even if its request arrives in the commit cycle.
    pend_d = pend_base | (req_eff & ~sel_oh);
    if (commit)        pend_d[cand] = 1'b0;
    if (open_hit)      pend_d[0]    = 1'b1;
    if (alarm_release) pend_d[0]    = 1'b1;

    if (commit && (cand == MSG_ALARM)) alarm_latch_d = 1'b1;
    else if (alarm_release)            alarm_latch_d = 1'b0;

    if (commit)                        open_cnt_d = '0;
    else if (open_hit)                 open_cnt_d = '0;
    else if ((state_q == ST_SHOW) && (sel_q == MSG_OPEN))
      open_cnt_d = open_cnt_q + OPEN_W'(1);

    if (commit && (cand == MSG_USER))  data_d = '0;
    else if (digits_valid)             data_d = digits_in;

    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_SHOW;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          // Nothing meaningful is on screen yet, so the first message need not wait.
          hold_cnt_d = HOLD_MAX;
        end else begin
          boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        end
      end
      ST_SHOW: begin
        if (commit) begin
          state_d    = ST_SWITCH;
          sel_d      = cand;
          mc_d       = 1'b1;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
          chg_cnt_d  = '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_SWITCH: begin
        if (chg_cnt_q == CHG_LAST) begin
          state_d = ST_SHOW;
          mc_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          chg_cnt_d = chg_cnt_q + CHG_W'(1);
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      state_q       <= ST_BOOT;
      boot_cnt_q    <= '0;
      chg_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      open_cnt_q    <= '0;
      pend_q        <= '0;
      alarm_latch_q <= 1'b0;
      ready_q       <= 1'b0;
      sel_q         <= MSG_USER;
      mc_q          <= 1'b0;
      data_q        <= '0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      boot_cnt_q    <= boot_cnt_d;
      chg_cnt_q     <= chg_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      open_cnt_q    <= open_cnt_d;
      pend_q        <= pend_d;
      alarm_latch_q <= alarm_latch_d;
      ready_q       <= ready_d;
      sel_q         <= sel_d;
      mc_q          <= mc_d;
      data_q        <= data_d;
      busy_q        <= busy_d;
    end
  end

  assign ready_o        = ready_q;
  assign sel_msg        = sel_q;
  assign message_change = mc_q;
  assign data_out       = data_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Testbench for lcd_msg_scheduler: a directed vector table walking through the
// main display scenarios, hand-written latency sequences, then randomized
// requests compared every cycle against a timestamp-based reference model.
module tb_lcd_msg_scheduler;

  localparam int P  = 10;  // power-up cycles
  localparam int C  = 4;   // message_change width
  localparam int H  = 8;   // minimum hold
  localparam int O  = 20;  // OPEN timeout
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_user, req_pass, req_open, req_alarm, alarm_clear;
  logic [DW-1:0] digits_in;
  logic          digits_valid;
  logic          ready_o;
  logic [1:0]    sel_msg;
  logic          message_change;
  logic [DW-1:0] data_out;
  logic          busy;

  always #5 clk = ~clk;

  lcd_msg_scheduler #(
    .POWERUP_CYCLES  (P),
    .CHANGE_CYCLES   (C),
    .MIN_HOLD_CYCLES (H),
    .OPEN_CYCLES     (O),
    .DIGITS_W        (DW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_user       (req_user),
    .req_pass       (req_pass),
    .req_open       (req_open),
    .req_alarm      (req_alarm),
    .alarm_clear    (alarm_clear),
    .digits_in      (digits_in),
    .digits_valid   (digits_valid),
    .ready_o        (ready_o),
    .sel_msg        (sel_msg),
    .message_change (message_change),
    .data_out       (data_out),
    .busy           (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Tracks time as cycle stamps: m_e = cycles since reset, m_ce = first cycle
  // after the last commit. Phases are derived from those stamps.
  int            m_e     = 0;
  bit            m_hc    = 1'b0;   // a commit has happened since reset
  int            m_ce    = 0;
  bit [3:0]      m_pend  = '0;     // index = message code
  bit            m_latch = 1'b0;
  int            m_sel   = 0;
  logic [DW-1:0] m_data  = '0;

  task automatic model_step(input logic rst, input logic [3:0] r, input logic clr,
                            input logic dv, input logic [DW-1:0] dig);
    bit show, hold_ok, commit, tmo;
    int s, cand;
    bit [3:0] p, rr;
    if (rst) begin
      m_e = 0; m_hc = 0; m_ce = 0; m_pend = '0; m_latch = 0; m_sel = 0; m_data = '0;
      return;
    end
    show    = (m_e >= P) && (!m_hc || m_e >= m_ce + C);
    s       = m_e - (m_ce + C);            // SHOW cycles since the last switch ended
    hold_ok = !m_hc || (s >= H);
    p  = m_pend;
    rr = r;
    if (m_latch) begin
      p[2:0]  = '0;
      rr[2:0] = '0;
    end
    cand = -1;
    for (int i = 3; i >= 0; i--)
      if (cand < 0 && (p[i] || rr[i]) && i != m_sel) cand = i;
    commit = show && (cand >= 0) && (cand == 3 || hold_ok);
    tmo    = show && !commit && (m_sel == 2) && (s == O);
    for (int i = 0; i < 4; i++)
      if (rr[i] && i != m_sel) p[i] = 1'b1;
    if (commit) p[cand] = 1'b0;
    if (tmo) p[0] = 1'b1;
    if (m_latch && clr && !r[3]) begin
      m_latch = 1'b0;
      p[0]    = 1'b1;
    end
    if (commit && cand == 3) m_latch = 1'b1;
    if (commit && cand == 0) m_data = '0;
    else if (dv)             m_data = dig;
    if (commit) begin
      m_sel = cand;
      m_hc  = 1'b1;
      m_ce  = m_e + 1;
    end
    m_pend = p;
    m_e++;
  endtask

  task automatic model_check();
    bit exp_ready, exp_mc;
    exp_ready = (m_e >= P);
    exp_mc    = m_hc && (m_e >= m_ce) && (m_e < m_ce + C);
    check("model ready_o", 32'(ready_o), 32'(exp_ready));
    check("model sel_msg", 32'(sel_msg), 32'(m_sel));
    check("model message_change", 32'(message_change), 32'(exp_mc));
    check("model data_out", 32'(data_out), 32'(m_data));
    check("model busy", 32'(busy), 32'(!exp_ready || exp_mc));
  endtask

  // One clock: drive inputs, let the edge pass, sample 1 time unit later.
  task automatic step(input logic rst, input logic [3:0] r, input logic clr,
                      input logic dv, input logic [DW-1:0] dig);
    reset        = rst;
    req_user     = r[0];
    req_pass     = r[1];
    req_open     = r[2];
    req_alarm    = r[3];
    alarm_clear  = clr;
    digits_valid = dv;
    digits_in    = dig;
    @(posedge clk);
    #1;
    model_step(rst, r, clr, dv, dig);
    model_check();
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 1'b0, '0);
  endtask

  // ---------------- directed vector table ----------------
  // req bits: [0]=USER [1]=PASS [2]=OPEN [3]=ALARM. Inputs are applied for one
  // cycle, followed by 'idle' quiet cycles, then outputs are compared.
  typedef struct {
    logic          rst;
    logic [3:0]    req;
    logic          clr;
    logic          dv;
    logic [DW-1:0] dig;
    int            idle;
    logic          ready;
    logic [1:0]    sel;
    logic          mc;
    logic [DW-1:0] data;
    logic          busy;
  } vec_t;

  localparam int NV = 31;
  vec_t v [NV];

  initial begin
    int cnt;
    int hi;

    // power-up then PASS requested during BOOT
    v[0]  = '{1'b1, 4'h0, 1'b0, 1'b0, 14'd0,    0,  1'b0, 2'd0, 1'b0, 14'd0,    1'b1}; // e=0
    v[1]  = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    2,  1'b0, 2'd0, 1'b0, 14'd0,    1'b1}; // e=3
    v[2]  = '{1'b0, 4'h2, 1'b0, 1'b0, 14'd0,    5,  1'b0, 2'd0, 1'b0, 14'd0,    1'b1}; // e=9
    v[3]  = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    0,  1'b1, 2'd0, 1'b0, 14'd0,    1'b0}; // e=10 ready
    v[4]  = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    0,  1'b1, 2'd1, 1'b1, 14'd0,    1'b1}; // e=11 PASS
    v[5]  = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    2,  1'b1, 2'd1, 1'b1, 14'd0,    1'b1}; // e=14
    v[6]  = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    0,  1'b1, 2'd1, 1'b0, 14'd0,    1'b0}; // e=15
    // OPEN held off by minimum hold, then auto-return to USER
    v[7]  = '{1'b0, 4'h4, 1'b0, 1'b1, 14'd1234, 7,  1'b1, 2'd1, 1'b0, 14'd1234, 1'b0}; // e=23
    v[8]  = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    0,  1'b1, 2'd2, 1'b1, 14'd1234, 1'b1}; // e=24 OPEN
    v[9]  = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    24, 1'b1, 2'd2, 1'b0, 14'd1234, 1'b0}; // e=49
    v[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    0,  1'b1, 2'd0, 1'b1, 14'd0,    1'b1}; // e=50 USER
    // simultaneous USER+PASS+OPEN while USER shown
    v[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    3,  1'b1, 2'd0, 1'b0, 14'd0,    1'b0}; // e=54
    v[12] = '{1'b0, 4'h7, 1'b0, 1'b0, 14'd0,    7,  1'b1, 2'd0, 1'b0, 14'd0,    1'b0}; // e=62
    v[13] = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    0,  1'b1, 2'd2, 1'b1, 14'd0,    1'b1}; // e=63 OPEN
    v[14] = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    11, 1'b1, 2'd2, 1'b0, 14'd0,    1'b0}; // e=75
    v[15] = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    0,  1'b1, 2'd1, 1'b1, 14'd0,    1'b1}; // e=76 PASS
    v[16] = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    13, 1'b1, 2'd1, 1'b0, 14'd0,    1'b0}; // e=90 USER dropped
    // USER commit with digits_valid in the same cycle: clear wins
    v[17] = '{1'b0, 4'h1, 1'b0, 1'b1, 14'd555,  0,  1'b1, 2'd0, 1'b1, 14'd0,    1'b1}; // e=91
    // ALARM during SWITCH does not shorten the pulse
    v[18] = '{1'b0, 4'h2, 1'b0, 1'b0, 14'd0,    11, 1'b1, 2'd0, 1'b0, 14'd0,    1'b0}; // e=103
    v[19] = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    0,  1'b1, 2'd1, 1'b1, 14'd0,    1'b1}; // e=104 PASS
    v[20] = '{1'b0, 4'h8, 1'b0, 1'b0, 14'd0,    0,  1'b1, 2'd1, 1'b1, 14'd0,    1'b1}; // e=105
    v[21] = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    2,  1'b1, 2'd1, 1'b0, 14'd0,    1'b0}; // e=108
    v[22] = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    0,  1'b1, 2'd3, 1'b1, 14'd0,    1'b1}; // e=109 ALARM
    v[23] = '{1'b0, 4'h1, 1'b0, 1'b0, 14'd0,    12, 1'b1, 2'd3, 1'b0, 14'd0,    1'b0}; // e=122 USER ignored
    v[24] = '{1'b0, 4'h8, 1'b1, 1'b1, 14'd1234, 0,  1'b1, 2'd3, 1'b0, 14'd1234, 1'b0}; // e=123 stays latched
    v[25] = '{1'b0, 4'h1, 1'b0, 1'b0, 14'd0,    2,  1'b1, 2'd3, 1'b0, 14'd1234, 1'b0}; // e=126
    v[26] = '{1'b0, 4'h0, 1'b1, 1'b0, 14'd0,    0,  1'b1, 2'd3, 1'b0, 14'd1234, 1'b0}; // e=127 released
    v[27] = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    0,  1'b1, 2'd0, 1'b1, 14'd0,    1'b1}; // e=128 USER
    // reset in the middle of SWITCH with OPEN pending
    v[28] = '{1'b0, 4'h4, 1'b0, 1'b1, 14'd1234, 0,  1'b1, 2'd0, 1'b1, 14'd1234, 1'b1}; // e=129
    v[29] = '{1'b1, 4'h0, 1'b0, 1'b0, 14'd0,    8,  1'b0, 2'd0, 1'b0, 14'd0,    1'b1}; // e=8
    v[30] = '{1'b0, 4'h0, 1'b0, 1'b0, 14'd0,    8,  1'b1, 2'd0, 1'b0, 14'd0,    1'b0}; // e=17

    for (int i = 0; i < NV; i++) begin
      step(v[i].rst, v[i].req, v[i].clr, v[i].dv, v[i].dig);
      for (int k = 0; k < v[i].idle; k++) idle();
      check($sformatf("vec%0d ready_o", i),        32'(ready_o),        32'(v[i].ready));
      check($sformatf("vec%0d sel_msg", i),        32'(sel_msg),        32'(v[i].sel));
      check($sformatf("vec%0d message_change", i), 32'(message_change), 32'(v[i].mc));
      check($sformatf("vec%0d data_out", i),       32'(data_out),       32'(v[i].data));
      check($sformatf("vec%0d busy", i),           32'(busy),           32'(v[i].busy));
    end

    // ---------------- hand-written latency sequences ----------------
    step(1'b1, 4'h0, 1'b0, 1'b0, '0);
    cnt = 0;
    while (ready_o !== 1'b1 && cnt < 50) begin
      idle();
      cnt++;
    end
    check("powerup latency", 32'(cnt), 32'(P));

    // ALARM on the first SHOW cycle commits at once; count the pulse width.
    step(1'b0, 4'h8, 1'b0, 1'b0, '0);
    check("alarm first-show commit", 32'(sel_msg), 32'(3));
    hi = 0;
    while (message_change === 1'b1 && hi < 50) begin
      hi++;
      idle();
    end
    check("message_change width", 32'(hi), 32'(C));

    // ---------------- randomized stimulus vs model ----------------
    step(1'b1, 4'h0, 1'b0, 1'b0, '0);
    for (int n = 0; n < 4000; n++) begin
      logic [3:0]    r;
      logic          clr, dv, rst;
      logic [DW-1:0] dig;
      r[0] = ($urandom_range(15) == 0);
      r[1] = ($urandom_range(15) == 0);
      r[2] = ($urandom_range(23) == 0);
      r[3] = ($urandom_range(47) == 0);
      clr  = ($urandom_range(15) == 0);
      dv   = ($urandom_range(7) == 0);
      dig  = DW'($urandom);
      rst  = ($urandom_range(999) == 0);
      step(rst, r, clr, dv, dig);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
